// File: rtl/req_arbiter8_pkg.sv
// Shared types and helpers for the 8-way request arbiter.
// Optional rotating priority is selected by REQ_ARBITER8_ROUND_ROBIN_EN.
package arb_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned CODE_W = 3;

    typedef logic [N_REQ-1:0]  req_t;
    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // Registered grant payload: one-hot vector plus its binary index
    typedef struct packed {
        req_t  gnt;
        code_t code;
    } grant_t;

    function automatic req_t onehot(code_t c);
        return req_t'(1) << c;
    endfunction

endpackage

// File: rtl/req_arbiter8_if.sv
// Request/grant bus between requesters (master) and the arbiter (slave).
interface req_arbiter8_if;
    import arb_pkg::*;

    logic  en;
    req_t  req;
    req_t  gnt;
    code_t gnt_code;
    logic  gnt_valid;
    logic  timeout;

    modport master (output en, req, input gnt, gnt_code, gnt_valid, timeout);
    modport slave  (input en, req, output gnt, gnt_code, gnt_valid, timeout);

endinterface

// File: rtl/req_arbiter8_prio_pick.sv
// Combinational descending search starting at 'start' and wrapping; start=7
// reproduces the fixed highest-index-wins priority.
module arb_prio_pick
    import arb_pkg::*;
(
    input  req_t  req,
    input  code_t start,
    output code_t winner,
    output logic  found
);

    code_t idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = start - CODE_W'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_arbiter8.sv
// 8-requester arbiter with registered one-hot grant, hold timeout and block mask.
// Define REQ_ARBITER8_ROUND_ROBIN_EN for rotating priority instead of fixed.
module req_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    req_arbiter8_if.slave  bus
);

    localparam int unsigned CNT_RAW = $clog2(MAX_HOLD + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

    arb_state_t       state;
    grant_t           grant_q;
    logic [CNT_W-1:0] cnt;
    req_t             block;
    logic             timeout_q;

    req_t  masked;
    code_t start;
    code_t winner;
    logic  found;
    logic  owner_req;
    logic  hold_hit;
    logic  block_drop;

`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
    code_t ptr;

    // Pointer remembers the last winner; search begins just below it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= CODE_W'(N_REQ - 1);
        end else if (state == IDLE && bus.en && found) begin
            ptr <= winner;
        end
    end

    assign start = ptr - CODE_W'(1);
`else
    assign start = CODE_W'(N_REQ - 1);
`endif

    assign masked     = bus.req & ~block;
    assign owner_req  = bus.req[grant_q.code];
    assign hold_hit   = (MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD));
    assign block_drop = (block & ~bus.req) != '0;

    arb_prio_pick u_pick (
        .req    (masked),
        .start  (start),
        .winner (winner),
        .found  (found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_q   <= '0;
            cnt       <= '0;
            block     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en && found) begin
                        state   <= GRANT;
                        grant_q <= '{gnt: onehot(winner), code: winner};
                        cnt     <= CNT_W'(1);
                        block   <= '0;
                    end else if (bus.en || block_drop) begin
                        // Block covers a single arbitration only
                        block <= '0;
                    end
                end
                GRANT: begin
                    if (block_drop) begin
                        block <= '0;
                    end
                    if (!owner_req) begin
                        state   <= IDLE;
                        grant_q <= '0;
                    end else if (hold_hit) begin
                        state     <= IDLE;
                        grant_q   <= '0;
                        block     <= onehot(grant_q.code);
                        timeout_q <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.gnt       = grant_q.gnt;
    assign bus.gnt_code  = grant_q.code;
    assign bus.gnt_valid = (state == GRANT);
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter8.sv
// Self-checking bench for req_arbiter8 (MAX_HOLD=4): directed vectors plus
// randomized traffic against a behavioural reference model.
module tb_req_arbiter8;
    import arb_pkg::*;

    localparam int MAXH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    req_arbiter8_if bus ();

    req_arbiter8 #(.MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] code;
        logic       tout;
    } vec_t;

    vec_t tbl [0:35];

    // Reference model: owner/block are indices, -1 meaning none
    int m_owner, m_held, m_block, m_last;
    bit m_tout;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_block = -1; m_last = 7; m_tout = 0;
    endtask

    task automatic model_step(input logic e, input logic [7:0] r);
        int w;
        int idx;
        m_tout = 0;
        if (m_owner < 0) begin
            w = -1;
            if (e) begin
                for (int k = 0; k < 8; k++) begin
`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
                    idx = (m_last + 7 - k) % 8;
`else
                    idx = 7 - k;
`endif
                    if (w < 0 && r[idx] && idx != m_block) w = idx;
                end
            end
            if (w >= 0) begin
                m_owner = w; m_held = 1; m_last = w; m_block = -1;
            end else if (e || (m_block >= 0 && !r[m_block])) begin
                m_block = -1;
            end
        end else begin
            if (m_block >= 0 && !r[m_block]) m_block = -1;
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (MAXH != 0 && m_held == MAXH) begin
                m_block = m_owner; m_owner = -1; m_tout = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_model(input int cyc);
        logic [7:0] eg;
        eg = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
        check($sformatf("rnd%0d gnt", cyc), bus.gnt, eg);
        check($sformatf("rnd%0d code", cyc), 8'(bus.gnt_code), (m_owner < 0) ? 8'h00 : 8'(m_owner));
        check($sformatf("rnd%0d valid", cyc), 8'(bus.gnt_valid), 8'(m_owner >= 0));
        check($sformatf("rnd%0d timeout", cyc), 8'(bus.timeout), 8'(m_tout));
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.en  = tbl[i].en;
            bus.req = tbl[i].req;
            @(posedge clk); #1;
            check($sformatf("row%0d gnt", i), bus.gnt, tbl[i].gnt);
            check($sformatf("row%0d code", i), 8'(bus.gnt_code), 8'(tbl[i].code));
            check($sformatf("row%0d valid", i), 8'(bus.gnt_valid), 8'(tbl[i].gnt != 8'h00));
            check($sformatf("row%0d timeout", i), 8'(bus.timeout), 8'(tbl[i].tout));
        end
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] flip;
        int         cur;
        int         rr_exp [0:8];

        tbl[0]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 8'h14, 8'h10, 3'd4, 1'b0};
        tbl[2]  = '{1'b1, 8'h14, 8'h10, 3'd4, 1'b0};
        tbl[3]  = '{1'b1, 8'h04, 8'h00, 3'd0, 1'b0};
        tbl[4]  = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b0};
        tbl[5]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[6]  = '{1'b1, 8'h42, 8'h40, 3'd6, 1'b0};
        tbl[7]  = '{1'b1, 8'h42, 8'h40, 3'd6, 1'b0};
        tbl[8]  = '{1'b1, 8'h42, 8'h40, 3'd6, 1'b0};
        tbl[9]  = '{1'b1, 8'h42, 8'h40, 3'd6, 1'b0};
        tbl[10] = '{1'b1, 8'h42, 8'h00, 3'd0, 1'b1};
        tbl[11] = '{1'b1, 8'h42, 8'h02, 3'd1, 1'b0};
        tbl[12] = '{1'b1, 8'h40, 8'h00, 3'd0, 1'b0};
        tbl[13] = '{1'b1, 8'h40, 8'h40, 3'd6, 1'b0};
        tbl[14] = '{1'b1, 8'h40, 8'h40, 3'd6, 1'b0};
        tbl[15] = '{1'b1, 8'h40, 8'h40, 3'd6, 1'b0};
        tbl[16] = '{1'b1, 8'h40, 8'h40, 3'd6, 1'b0};
        tbl[17] = '{1'b1, 8'h40, 8'h00, 3'd0, 1'b1};
        tbl[18] = '{1'b1, 8'h40, 8'h00, 3'd0, 1'b0};
        tbl[19] = '{1'b1, 8'h40, 8'h40, 3'd6, 1'b0};
        tbl[20] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[21] = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0};
        tbl[22] = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0};
        tbl[23] = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b0};
        tbl[24] = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b0};
        tbl[25] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[26] = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0};
        tbl[27] = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0};
        tbl[28] = '{1'b1, 8'h08, 8'h08, 3'd3, 1'b0};
        tbl[29] = '{1'b1, 8'h10, 8'h10, 3'd4, 1'b0};
        tbl[30] = '{1'b1, 8'h10, 8'h10, 3'd4, 1'b0};
        tbl[31] = '{1'b1, 8'h10, 8'h10, 3'd4, 1'b0};
        tbl[32] = '{1'b1, 8'h10, 8'h10, 3'd4, 1'b0};
        tbl[33] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[34] = '{1'b1, 8'h10, 8'h10, 3'd4, 1'b0};
        tbl[35] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
        rr_exp = '{6, 5, 4, 3, 2, 1, 0, 7, 6};

        // Reset holds everything clear even with all requests pending
        rst_n   = 1'b0;
        bus.en  = 1'b1;
        bus.req = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("reset gnt", bus.gnt, 8'h00);
        check("reset code", 8'(bus.gnt_code), 8'h00);
        check("reset valid", 8'(bus.gnt_valid), 8'h00);
        check("reset timeout", 8'(bus.timeout), 8'h00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
        check("rr first code", 8'(bus.gnt_code), 8'(rr_exp[0]));
        check("rr first gnt", bus.gnt, 8'(1 << rr_exp[0]));
        cur = rr_exp[0];
        for (int i = 1; i <= 8; i++) begin
            bus.req = 8'hFF & ~8'(1 << cur);
            @(posedge clk); #1;
            check($sformatf("rr idle%0d gnt", i), bus.gnt, 8'h00);
            bus.req = 8'hFF;
            @(posedge clk); #1;
            check($sformatf("rr step%0d code", i), 8'(bus.gnt_code), 8'(rr_exp[i]));
            check($sformatf("rr step%0d gnt", i), bus.gnt, 8'(1 << rr_exp[i]));
            cur = rr_exp[i];
        end
`else
        check("post-reset gnt", bus.gnt, 8'h80);
        check("post-reset code", 8'(bus.gnt_code), 8'h07);
        check("post-reset valid", 8'(bus.gnt_valid), 8'h01);
        run_rows(0, 28);

        // Asynchronous clear mid-grant, before the next rising edge
        #2 rst_n = 1'b0;
        #1;
        check("async gnt", bus.gnt, 8'h00);
        check("async code", 8'(bus.gnt_code), 8'h00);
        check("async valid", 8'(bus.gnt_valid), 8'h00);
        @(negedge clk);
        bus.req = 8'h00;
        bus.en  = 1'b1;
        rst_n   = 1'b1;
        run_rows(29, 35);
`endif

        // Randomized sticky traffic against the reference model
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = 8'h00;
        bus.en  = 1'b0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        r = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            flip = 8'h00;
            for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(0, 5) == 0);
            r = r ^ flip;
            if ($urandom_range(0, 31) == 0) r = 8'h00;
            bus.req = r;
            bus.en  = ($urandom_range(0, 7) != 0);
            model_step(bus.en, bus.req);
            @(posedge clk); #1;
            check_model(c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/req_arbiter8.md
Name: req_arbiter8

Overview:
- Arbitrates one shared resource among 8 requesters.
- Its grant is one-hot, plus a 3-bit binary code using the same convention as the team's 8-input priority encoder: the highest set bit gives the code, index 7 = 3'b111.
- Grants are registered and held until the requester releases or a hold timeout fires.
- Sits in front of any shared datapath unit that needs a single owner per transaction.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles per owner; 0 = unlimited (timeout logic disabled); legal values 0 or >=2.
- CNT_W, $clog2(MAX_HOLD+1) with a minimum of 1: width of the hold counter (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; gates new grants only.
- req  input  8  request vector; req[i] high = requester i wants or keeps the resource.
- gnt  output  8  one-hot grant, registered; 0 when idle.
- gnt_code  output  3  binary index of gnt; 3'b000 when idle.
- gnt_valid  output  1  high while any grant is active (equals |gnt).
- timeout  output  1  single-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset, asynchronous, no clock needed:
  - gnt=0, gnt_code=0, gnt_valid=0, timeout=0.
  - state=IDLE, hold counter=0, block mask=0, rr pointer=7.
- State IDLE: when en=1 and (req & ~block)!=0, pick the winner.
  - Next edge: state=GRANT, gnt=onehot(winner), gnt_code=winner, gnt_valid=1, counter=1.
  - Latency from sampled request to grant: 1 clock.
- Fixed priority: highest set index of (req & ~block) wins.
- Block mask:
  - Holds the index of the last timed-out owner; excludes it from the next arbitration only.
  - Cleared on the first IDLE-cycle arbitration that produces a grant.
  - Also cleared if the blocked requester drops req.
  - If only the blocked requester is requesting, no grant is issued; the mask clears after that cycle, so the requester is granted one cycle later.
- State GRANT: owner keeps the grant while req[owner]=1.
  - Counter increments each GRANT cycle and saturates.
  - Release: req[owner]=0 at an edge -> next cycle gnt=0, gnt_code=0, gnt_valid=0, state=IDLE.
  - Re-arbitration happens in that IDLE cycle, so at least 1 idle cycle separates consecutive grants.
  - Timeout (MAX_HOLD!=0): in GRANT with counter==MAX_HOLD and req[owner]=1 -> next cycle gnt=0, timeout=1 for exactly one cycle, block=owner, state=IDLE.
  - The owner therefore holds the grant for exactly MAX_HOLD cycles.
  - Release and timeout condition in the same cycle: release wins, no timeout pulse, no block.
- en:
  - en=0 suppresses new grants in IDLE.
  - Dropping en during GRANT does not revoke the grant; it affects the next arbitration only.
- req changes on non-owner lines during GRANT are ignored.
- Reset asserted mid-grant: all outputs clear immediately, asynchronously.
- Invariants: gnt is always one-hot or zero; gnt_code == encode(gnt); gnt_valid == |gnt.

Optional Feature:
- Macro: REQ_ARBITER8_ROUND_ROBIN_EN.
- Defined: rotating priority. The rr pointer stores the last granted index, updated on each grant. Search order is ptr-1, ptr-2, …, 0, 7, …, ptr (descending, wrapping). The block mask still applies. After reset, ptr=7, so the first search starts at index 6; index 7 is checked last.
- Undefined: fixed priority as above; no pointer register is synthesized.

Decomposition:
- Package arb_pkg:
  - N_REQ=8, CODE_W=3.
  - typedef req_t logic[7:0]; typedef code_t logic[2:0].
  - typedef enum logic {IDLE, GRANT} arb_state_t.
- Sub-module arb_prio_pick (combinational):
  - Inputs: masked req, start pointer.
  - Outputs: winner code_t and found flag.
  - Rotating priority search; with pointer tied to 7 it degenerates to the encoder's fixed priority.

Test Plan:
- Reset: rst_n=0, req=8'hFF, en=1 -> gnt=0, timeout=0. Deassert rst_n at an edge -> after next edge gnt=8'h80, gnt_code=3'b111, gnt_valid=1.
- Release: req=8'b0001_0100 at edge 0 -> edge1 gnt=8'h10/code 100. Drop req[4] before edge3 -> edge3 gnt=0. Edge4 gnt=8'h04/code 010.
- Timeout, MAX_HOLD=4: req[6] and req[1] held high.
  - gnt=8'h40 for exactly 4 cycles.
  - Then gnt=0 with timeout=1 for one cycle.
  - Then gnt=8'h02.
  - Drop req[1] -> one idle cycle, then gnt=8'h40 again.
  - Variant: only req[6] high -> gnt=0 for 2 cycles (timeout, blocked), then gnt=8'h40.
- en: en=0, req=8'hFF -> gnt stays 0. en=0 asserted during an active 8'h20 grant -> grant held until req[5] drops, then no new grant.
- Async reset mid-grant: drop rst_n between edges while gnt=8'h08 -> gnt, gnt_code, gnt_valid read 0 before the next clock edge.
- With REQ_ARBITER8_ROUND_ROBIN_EN, MAX_HOLD=0: all requesters assert req, each releasing 1 cycle after being granted and re-asserting -> gnt_code sequence 6,5,4,3,2,1,0,7,6 (each grant separated by one idle cycle).
